file_read_write: RTL and testbench

- Single-port-style 1024 x 16 sample buffer that stores one "file" of input samples for downstream FFT processing.
- A write session is opened with start_write, filled with addressed writes, and closed with end_write.
- Stored words are read back by address with one-cycle registered latency.
- Tracks file length so that reads beyond the written extent return zero.

---
 rtl/file_read_write.sv | 93 +++++++++
 tb/tb_file_read_write.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/file_read_write.sv
// 1024 x 16 sample buffer holding one "file" of samples for downstream FFT processing.
// Addressed writes inside an open session, registered reads gated by the tracked file length.
module file_read_write #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic              start_write,
    input  logic              end_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] input_data,
    output logic [DATA_W-1:0] output_data,
    output logic              file_open,
    output logic              file_valid,
    output logic [ADDR_W:0]   file_len
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        CLOSED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d, len_base;
    logic [ADDR_W:0]   addr_ext, addr_p1;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_ok;

    logic [DATA_W-1:0] mem [DEPTH];

    assign addr_ext = {1'b0, address};
    assign addr_p1  = addr_ext + (ADDR_W + 1)'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        len_d    = len_q;
        rdata_d  = rdata_q;
        wr_ok    = 1'b0;
        len_base = len_q;

        // start_write dominates end_write and always (re)opens with an empty file.
        if (start_write) begin
            state_d  = OPEN;
            len_base = '0;
        end else if (end_write && state_q == OPEN) begin
            state_d = CLOSED;
        end

        wr_ok = write_enable && (start_write || state_q == OPEN);
        len_d = len_base;
        if (wr_ok && addr_p1 > len_base) begin
            len_d = addr_p1;
        end

        // Read gating uses the pre-edge length, so a first-time write reads back as zero.
        if (read_enable) begin
            rdata_d = (addr_ext < len_q) ? mem[address] : '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!n_rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the array is deliberately not reset; file_len = 0 makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[address] <= input_data;
        end
    end

    assign output_data = rdata_q;
    assign file_open   = (state_q == OPEN);
    assign file_valid  = (state_q == CLOSED);
    assign file_len    = len_q;

endmodule

// File: tb/tb_file_read_write.sv
// Scoreboard bench for file_read_write: read expectations are queued at issue time and
// popped by a monitor when the registered read data becomes visible one cycle later.
module tb_file_read_write;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    logic              clk;
    logic              n_rst;
    logic              read_enable;
    logic              write_enable;
    logic              start_write;
    logic              end_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] input_data;
    logic [DATA_W-1:0] output_data;
    logic              file_open;
    logic              file_valid;
    logic [ADDR_W:0]   file_len;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_q [$];
    string             name_q [$];
    logic              rd_fire;

    file_read_write #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .start_write  (start_write),
        .end_write    (end_write),
        .address      (address),
        .input_data   (input_data),
        .output_data  (output_data),
        .file_open    (file_open),
        .file_valid   (file_valid),
        .file_len     (file_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: remember which edges carried a read, then compare on the following falling edge.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) rd_fire = 1'b0;
        else        rd_fire = read_enable;
    end

    always @(negedge clk) begin
        if (rd_fire && n_rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", 32'(output_data), 32'hFFFF_FFFF);
            end else begin
                check(name_q.pop_front(), 32'(output_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; a read pushes its hand-computed expectation.
    task automatic op(input string name, input logic rd, input logic wr, input logic sw,
                      input logic ew, input int addr, input int data, input int exp_rd);
        read_enable  = rd;
        write_enable = wr;
        start_write  = sw;
        end_write    = ew;
        address      = ADDR_W'(addr);
        input_data   = DATA_W'(data);
        if (rd) begin
            exp_q.push_back(DATA_W'(exp_rd));
            name_q.push_back(name);
        end
        @(posedge clk);
        #1;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        start_write  = 1'b0;
        end_write    = 1'b0;
    endtask

    task automatic wr(input int addr, input int data);
        op("write", 1'b0, 1'b1, 1'b0, 1'b0, addr, data, 0);
    endtask

    task automatic rd(input string name, input int addr, input int exp_rd);
        op(name, 1'b1, 1'b0, 1'b0, 1'b0, addr, 0, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst        = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        start_write  = 1'b0;
        end_write    = 1'b0;
        address      = '0;
        input_data   = '0;
        repeat (3) @(posedge clk);
        #3 n_rst = 1'b1;
        @(posedge clk);
        #1;

        check("reset_file_open", 32'(file_open), 0);
        check("reset_file_valid", 32'(file_valid), 0);
        check("reset_file_len", 32'(file_len), 0);
        check("reset_output_data", 32'(output_data), 0);
        rd("idle_read_addr0", 0, 0);

        // Session 1: overwrite address 0 repeatedly; last value wins.
        op("start", 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        check("open_after_start", 32'(file_open), 1);
        check("len_after_start", 32'(file_len), 0);
        wr(0, 'h41); wr(0, 'h43); wr(0, 'h45); wr(0, 'h47); wr(0, 'h49);
        op("end", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        check("s1_file_valid", 32'(file_valid), 1);
        check("s1_file_open", 32'(file_open), 0);
        check("s1_file_len", 32'(file_len), 1);
        rd("s1_read_addr0", 0, 'h49);

        // Session 2: write on the opening edge, then 1..3; read past the end gives zero.
        op("start_wr", 1'b0, 1'b1, 1'b1, 1'b0, 0, 'h41, 0);
        check("s2_len_on_open_edge", 32'(file_len), 1);
        wr(1, 'h42); wr(2, 'h43); wr(3, 'h44);
        op("end", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        check("s2_file_len", 32'(file_len), 4);
        for (int i = 0; i < 5; i++) begin
            rd($sformatf("s2_read_addr%0d", i), i, (i < 4) ? 'h41 + i : 0);
        end

        // Closed: writes and end_write are ignored.
        wr(0, 'hBEEF);
        op("end_in_closed", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        check("closed_len_unchanged", 32'(file_len), 4);
        check("closed_still_valid", 32'(file_valid), 1);
        rd("closed_write_ignored", 0, 'h41);

        // Session 3: read-before-write, first-time write reads zero, end with write.
        op("start", 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        rd("restart_hides_old", 0, 0);
        wr(0, 'h41); wr(1, 'h42); wr(2, 'h43); wr(3, 'h44);
        op("rw_same_addr_old", 1'b1, 1'b1, 1'b0, 1'b0, 2, 'h1234, 'h43);
        rd("rw_same_addr_new", 2, 'h1234);
        op("first_write_reads_0", 1'b1, 1'b1, 1'b0, 1'b0, 4, 'h55, 0);
        rd("read_after_first_write", 4, 'h55);
        op("end_with_write", 1'b0, 1'b1, 1'b0, 1'b1, 5, 'h66, 0);
        check("end_with_write_len", 32'(file_len), 6);
        check("end_with_write_valid", 32'(file_valid), 1);
        rd("end_with_write_data", 5, 'h66);

        // start_write beats end_write.
        op("start_and_end", 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        check("start_wins_open", 32'(file_open), 1);
        check("start_wins_len", 32'(file_len), 0);

        // Asynchronous reset mid-session.
        wr(0, 'h77);
        rd("pre_reset_read", 0, 'h77);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_output", 32'(output_data), 0);
        check("async_rst_open", 32'(file_open), 0);
        check("async_rst_len", 32'(file_len), 0);
        @(posedge clk);
        #3 n_rst = 1'b1;
        @(posedge clk);
        #1;
        rd("post_reset_read", 0, 0);

        // Top address saturates the length at 1024; lower writes keep the max.
        op("start_wr_top", 1'b0, 1'b1, 1'b1, 1'b0, 1023, 'hABCD, 0);
        check("len_full", 32'(file_len), 1024);
        wr(5, 'h1111);
        check("len_keeps_max", 32'(file_len), 1024);
        rd("read_top", 1023, 'hABCD);
        op("restart_open", 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        check("restart_clears_len", 32'(file_len), 0);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
